// File: rtl/imm_encoder_pkg.sv
// Shared RV32 immediate-format codes and per-format immediate bit masks.
// The encoder and the immediate extender both rely on these encodings.
package imm_encoder_pkg;

  localparam logic [2:0] IMMSRC_ITYPE = 3'd0;
  localparam logic [2:0] IMMSRC_STYPE = 3'd1;
  localparam logic [2:0] IMMSRC_BTYPE = 3'd2;
  localparam logic [2:0] IMMSRC_JTYPE = 3'd3;
  localparam logic [2:0] IMMSRC_UTYPE = 3'd4;

  localparam logic [31:0] IMM_MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] IMM_MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] IMM_MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] IMM_MASK_J = 32'hFFFF_F000;
  localparam logic [31:0] IMM_MASK_U = 32'hFFFF_F000;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
    logic [31:0] fields;
    logic        err;
  } s1_t;

  // True when v[31:lsb] are all equal, i.e. v is a sign extension of v[lsb:0].
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] t;
    t = 32'($signed(v) >>> lsb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_scatter.sv
// Combinational scatter of an immediate into its RV32 instruction bit positions,
// with the mask of those positions and a representability flag.
module imm_scatter
  import imm_encoder_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic [2:0]  immsrc,
  input  logic [31:0] imm,
  output logic [31:0] mask,
  output logic [31:0] fields,
  output logic        err
);

  logic range_bad;

  always_comb begin
    mask      = '0;
    fields    = '0;
    range_bad = 1'b0;
    err       = 1'b0;
    case (immsrc)
      IMMSRC_ITYPE: begin
        mask      = IMM_MASK_I;
        fields    = {imm[11:0], 20'b0};
        range_bad = !sext_ok(imm, 11);
      end
      IMMSRC_STYPE: begin
        mask      = IMM_MASK_S;
        fields    = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_bad = !sext_ok(imm, 11);
      end
      IMMSRC_BTYPE: begin
        mask      = IMM_MASK_B;
        fields    = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_bad = imm[0] || !sext_ok(imm, 12);
      end
      IMMSRC_JTYPE: begin
        mask      = IMM_MASK_J;
        fields    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_bad = imm[0] || !sext_ok(imm, 20);
      end
      IMMSRC_UTYPE: begin
        mask      = IMM_MASK_U;
        fields    = {imm[31:12], 12'b0};
        range_bad = (imm[11:0] != 12'b0);
      end
      default: begin
        // Unknown format: leave base untouched and always flag it.
        err = 1'b1;
      end
    endcase
    if (CHECK_EN && range_bad) err = 1'b1;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that merges a scattered immediate into a base
// instruction word and counts delivered results flagged as unrepresentable.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          immsrc,
  input  logic [31:0]         imm,
  input  logic [31:0]         base_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         instr,
  output logic                imm_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  logic            s1_load, s2_load;

  imm_scatter #(.CHECK_EN(CHECK_EN)) u_scatter (
    .immsrc (immsrc),
    .imm    (imm),
    .mask   (s1_d.mask),
    .fields (s1_d.fields),
    .err    (s1_d.err)
  );
  assign s1_d.base = base_instr;

  // No skid buffer: acceptance depends combinationally on out_ready.
  assign s2_load   = !vld_pipe[2] || out_ready;
  assign s1_load   = !vld_pipe[1] || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      instr    <= '0;
      imm_err  <= 1'b0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          instr   <= (s1_q.base & ~s1_q.mask) | s1_q.fields;
          imm_err <= s1_q.err;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (CHECK_EN && out_valid && out_ready && imm_err && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: formats, range errors,
// backpressure ordering, unknown format, counter saturation and async reset.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic        clk, resetn;
  logic        in_valid, in_ready, out_valid, out_ready, imm_err;
  logic [2:0]  immsrc;
  logic [31:0] imm, base_instr, instr;
  logic [7:0]  err_count;

  int n_chk  = 0;
  int n_pass = 0;

  imm_encoder #(.CHECK_EN(1'b1), .ERRCNT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .immsrc     (immsrc),
    .imm        (imm),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .imm_err    (imm_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One isolated request with out_ready=1; checks two-cycle latency and result.
  task automatic do_one(input string tag, input logic [2:0] src, input logic [31:0] im,
                        input logic [31:0] base, input logic [31:0] exp_instr,
                        input logic exp_err);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; immsrc = src; imm = im; base_instr = base;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, instr, exp_instr);
    chk({tag, "_err"}, 32'(imm_err), 32'(exp_err));
  endtask

  task automatic stream_err(input int n);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; immsrc = 3'b111; imm = '0; base_instr = 32'h1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    immsrc = '0; imm = '0; base_instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", 32'(imm_err), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    resetn = 1'b1;

    do_one("i_neg", IMMSRC_ITYPE, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    do_one("b_ok",  IMMSRC_BTYPE, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    do_one("b_big", IMMSRC_BTYPE, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1);
    @(negedge clk);
    chk("cnt1", 32'(err_count), 32'd1);
    do_one("u",     IMMSRC_UTYPE, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
    do_one("j_odd", IMMSRC_JTYPE, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 1'b1);
    do_one("s",     IMMSRC_STYPE, 32'hFFFF_FFF8, 32'h0000_2023, 32'hFE00_2C23, 1'b0);
    do_one("j_ok",  IMMSRC_JTYPE, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
    @(negedge clk);
    chk("cnt2", 32'(err_count), 32'd2);

    // Backpressure: three back-to-back I-type requests against a stalled sink.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; immsrc = IMMSRC_ITYPE; imm = 32'd1; base_instr = 32'h13;
    @(negedge clk);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    imm = 32'd2;
    @(negedge clk);
    chk("bp_full", 32'(in_ready), 32'd0);
    imm = 32'd3;
    for (int i = 0; i < 4; i++) begin
      chk("bp_stall_vld", 32'(out_valid), 32'd1);
      chk("bp_stable", instr, 32'h0010_0013);
      chk("bp_stall_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_o2", instr, 32'h0020_0013);
    @(negedge clk);
    chk("bp_o3_vld", 32'(out_valid), 32'd1);
    chk("bp_o3", instr, 32'h0030_0013);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Unknown format passes base through and always errors; then saturate.
    do_one("unk", 3'b111, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("cnt3", 32'(err_count), 32'd3);
    stream_err(251);
    chk("cnt254", 32'(err_count), 32'd254);
    stream_err(50);
    chk("cnt_sat", 32'(err_count), 32'd255);

    // Async reset with both stages occupied.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; immsrc = IMMSRC_ITYPE; imm = 32'd5; base_instr = 32'h13;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_cnt", 32'(err_count), 32'd0);
    chk("arst_instr", instr, 32'd0);
    @(negedge clk);
    resetn = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_vld", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
